// File: rtl/fifo_ctrl.sv
// Registered control and storage core of a 32-entry FIFO: request decode, pointers, occupancy and read data.
// Optional build macro FIFO_DOUT_ZERO_EN: dout is cleared on every edge that is not a READ.
module fifo_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [2:0]            state,
  output logic [5:0]            data_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    WRITE    = 3'b001,
    READ     = 3'b010,
    WR_ERROR = 3'b011,
    RD_ERROR = 3'b100
  } state_e;

  localparam logic [5:0] FULL_COUNT = 6'd32;

  logic [DATA_WIDTH-1:0] mem_q [32];
  logic [4:0]            head_q, head_d;
  logic [4:0]            tail_q, tail_d;
  logic [5:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  state_e                state_q, state_d;
  logic                  mem_we;

  // Next state depends only on this cycle's requests and occupancy; write wins over read.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = IDLE;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_we  = 1'b0;
`ifdef FIFO_DOUT_ZERO_EN
    dout_d  = '0;
`else
    dout_d  = dout_q;
`endif
    if (wr_en) begin
      if (count_q != FULL_COUNT) begin
        state_d = WRITE;
        mem_we  = 1'b1;
        tail_d  = tail_q + 5'd1;
        count_d = count_q + 6'd1;
      end else begin
        state_d = WR_ERROR;
      end
    end else if (rd_en) begin
      if (count_q != 6'd0) begin
        state_d = READ;
        dout_d  = mem_q[head_q];
        head_d  = head_q + 5'd1;
        count_d = count_q - 6'd1;
      end else begin
        state_d = RD_ERROR;
      end
    end
  end

  // NOTE: storage has no reset; after reset it is unreachable until rewritten.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[tail_q] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  assign state      = state_q;
  assign data_count = count_q;
  assign dout       = dout_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl: a vector table for short sequences plus hand-written
// sequences for fill/drain, reset mid-stream, simultaneous requests and pointer wrap.
module tb_fifo_ctrl;

  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_WRITE = 3'b001;
  localparam logic [2:0] S_READ  = 3'b010;
  localparam logic [2:0] S_WERR  = 3'b011;
  localparam logic [2:0] S_RERR  = 3'b100;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] din;
  logic [31:0] dout;
  logic [2:0]  state;
  logic [5:0]  data_count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] din;
    logic [2:0]  st;
    logic [5:0]  cnt;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs [10];

  fifo_ctrl #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .din        (din),
    .dout       (dout),
    .state      (state),
    .data_count (data_count)
  );

  always #5 clk = ~clk;

  // Expected dout on a non-READ edge: held value, or zero when the clearing option is built in.
  function automatic logic [31:0] hold(input logic [31:0] v);
`ifdef FIFO_DOUT_ZERO_EN
    return 32'h0;
`else
    return v;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic [31:0] d,
                      input logic [2:0] es, input logic [5:0] ec, input logic [31:0] ed,
                      input string tag);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check({tag, " state"}, {29'd0, state}, {29'd0, es});
    check({tag, " count"}, {26'd0, data_count}, {26'd0, ec});
    check({tag, " dout"}, dout, ed);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    check("async reset state", {29'd0, state}, 32'd0);
    check("async reset count", {26'd0, data_count}, 32'd0);
    check("async reset dout", dout, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;

    vecs[0] = '{1'b0, 1'b1, 32'h0,  S_RERR,  6'd0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h11, S_WRITE, 6'd1, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h22, S_WRITE, 6'd2, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h0,  S_IDLE,  6'd2, 32'h0};
    vecs[4] = '{1'b0, 1'b1, 32'h0,  S_READ,  6'd1, 32'h11};
    vecs[5] = '{1'b1, 1'b1, 32'h33, S_WRITE, 6'd2, hold(32'h11)};
    vecs[6] = '{1'b0, 1'b1, 32'h0,  S_READ,  6'd1, 32'h22};
    vecs[7] = '{1'b0, 1'b1, 32'h0,  S_READ,  6'd0, 32'h33};
    vecs[8] = '{1'b0, 1'b1, 32'h0,  S_RERR,  6'd0, hold(32'h33)};
    vecs[9] = '{1'b0, 1'b0, 32'h0,  S_IDLE,  6'd0, hold(32'h33)};

    repeat (2) @(posedge clk);
    #1;
    check("reset state", {29'd0, state}, 32'd0);
    check("reset count", {26'd0, data_count}, 32'd0);
    check("reset dout", dout, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      step(vecs[i].wr, vecs[i].rd, vecs[i].din, vecs[i].st, vecs[i].cnt, vecs[i].dout,
           $sformatf("vec%0d", i));

    // Reset mid-stream after five writes discards the queued data.
    for (int i = 1; i <= 5; i++)
      step(1'b1, 1'b0, 32'h50 + i, S_WRITE, 6'(i), hold(32'h33), "pre-reset wr");
    pulse_reset();
    step(1'b0, 1'b1, 32'h0, S_RERR, 6'd0, 32'h0, "post-reset rd");

    // Fill to 32, then overflow attempts.
    for (int i = 1; i <= 32; i++)
      step(1'b1, 1'b0, 32'(i), S_WRITE, 6'(i), 32'h0, "fill");
    step(1'b1, 1'b0, 32'hFF, S_WERR, 6'd32, 32'h0, "overflow wr");
    step(1'b1, 1'b1, 32'h77, S_WERR, 6'd32, 32'h0, "full wr+rd");
    step(1'b0, 1'b0, 32'h0,  S_IDLE, 6'd32, 32'h0, "full idle");

    // Drain in order; 0xFF and 0x77 must never appear.
    for (int i = 1; i <= 32; i++)
      step(1'b0, 1'b1, 32'h0, S_READ, 6'(32 - i), 32'(i), "drain");
    step(1'b0, 1'b1, 32'h0, S_RERR, 6'd0, hold(32'h20), "underflow rd");

    // Simultaneous requests at count 5: write wins, dout not updated by a read.
    for (int i = 1; i <= 5; i++)
      step(1'b1, 1'b0, 32'h40 + i, S_WRITE, 6'(i), hold(32'h20), "pre-sim wr");
    step(1'b1, 1'b1, 32'h46, S_WRITE, 6'd6, hold(32'h20), "sim wr+rd");
    for (int i = 1; i <= 6; i++)
      step(1'b0, 1'b1, 32'h0, S_READ, 6'(6 - i), 32'h40 + i, "post-sim rd");

    // Wrap-around from a fresh reset: 20 in/out, then 24 more crossing index 31.
    pulse_reset();
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b0, 32'h60 + i, S_WRITE, 6'(i + 1), 32'h0, "wrap wr20");
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b1, 32'h0, S_READ, 6'(19 - i), 32'h60 + i, "wrap rd20");
    for (int i = 0; i < 24; i++)
      step(1'b1, 1'b0, 32'hA0 + i, S_WRITE, 6'(i + 1), hold(32'h73), "wrap wr24");
    for (int i = 0; i < 24; i++)
      step(1'b0, 1'b1, 32'h0, S_READ, 6'(23 - i), 32'hA0 + i, "wrap rd24");
    check("wrap head", {27'd0, dut.head_q}, 32'd12);
    check("wrap tail", {27'd0, dut.tail_q}, 32'd12);
    step(1'b0, 1'b0, 32'h0, S_IDLE, 6'd0, hold(32'hB7), "final idle");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
